if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
// Instruction-fetch stage of pipeline_cpu: owns the PC register, drives the
// word address of the instruction memory (IM) and loads the IF/ID pipeline
// register (ID_pc, ID_instruction) consumed by the decode stage.
// Handles load-use stalls, branch/jump redirects from ID and an optional
// branch delay slot.
// PARAMETERS
// RESET_PC    32'h0000_3000  PC value after reset (byte address)
// IM_BASE     32'h0000_3000  byte address of IM word 0
// IM_AW       10             IM word-address width (IM holds 2**IM_AW words)
// DELAY_SLOT  0              1: instruction fetched behind a branch executes; 0: it is flushed
// PORTS
// clock           in   1      rising-edge clock
// reset           in   1      asynchronous, active-low reset
// stall           in   1      hazard unit: hold PC and IF/ID this cycle
// redirect        in   1      taken branch/jump resolved in ID this cycle
// redirect_pc     in   32     target byte address of redirect
// im_addr         out  IM_AW  IM word index = (pc - IM_BASE) >> 2, combinational from pc
// im_rdata        in   32     IM read data for im_addr (combinational IM)
// pc              out  32     current fetch PC
// ID_pc           out  32     PC of instruction held in IF/ID
// ID_instruction  out  32     instruction held in IF/ID (32'h0 = nop bubble)
// ID_valid        out  1      IF/ID holds a real instruction
// fetch_fault     out  1      sticky: a fetch addressed outside IM or was misaligned
// fetch_count     out  32     number of valid instructions loaded into IF/ID
// BEHAVIOUR
// - Reset (reset==0, async): pc=RESET_PC, ID_pc=0, ID_instruction=0, ID_valid=0,
//   fetch_fault=0, fetch_count=0. Release takes effect at first following rising edge.
// - First valid instruction appears in IF/ID one edge after reset release (latency 1).
// - Per rising edge, priority redirect > stall > normal:
//   normal  : pc<=pc+4 (mod 2**32); IF/ID<={pc, im_rdata}, ID_valid<=1; fetch_count++.
//   stall   : pc and IF/ID unchanged; fetch_count unchanged.
//   redirect: pc<={redirect_pc[31:2],2'b00}.
//     DELAY_SLOT=1: IF/ID<={pc, im_rdata}, ID_valid<=1, fetch_count++ (slot executes).
//     DELAY_SLOT=0: IF/ID<={32'h0,32'h0}, ID_valid<=0 (bubble); fetch_count unchanged.
// - redirect with stall: redirect wins; stall is ignored that cycle.
// - Misaligned redirect_pc (bits[1:0]!=0): low bits dropped, fetch_fault<=1.
// - Out-of-range fetch: pc<IM_BASE or pc>=IM_BASE+4*2**IM_AW: im_addr is don't-care,
//   IF/ID loads instruction 32'h0 with ID_valid=1 (nop executes), fetch_fault<=1.
// - fetch_fault clears only on reset. fetch_count wraps 2**32-1 -> 0.
// - Reset asserted mid-stall or mid-redirect: all state returns to reset values
//   immediately; pending redirect is lost.
// - No combinational path from stall/redirect to im_addr (im_addr depends on pc only).
// TESTING
// 1. Reset pulse, IM words 0..3 = 11111111..44444444, no stall -> after edges 1..4
//    ID_pc=3000,3004,3008,300C with matching instructions; fetch_count=4.
// 2. stall high 2 cycles after edge 2 -> ID_pc holds 3004 for 3 edges, pc holds
//    3008; fetch_count frozen at 2, then resumes.
// 3. DELAY_SLOT=0, redirect to 3040 while pc=300C -> next edge ID_valid=0,
//    ID_instruction=0; following edge ID_pc=3040. Same with DELAY_SLOT=1 ->
//    ID_pc=300C valid, then 3040.
// 4. redirect and stall together, target 3020 -> pc=3020 next edge; stall ignored.
// 5. redirect_pc=3023 -> pc=3020, fetch_fault=1; redirect to 0000_0000 -> ID
//    loads nop with ID_valid=1, fetch_fault stays 1 until reset.
// 6. Assert reset for 2 ns mid-run (between edges) -> outputs at reset values
//    asynchronously; refetch starts at 3000 after release.

Source files
------------

// File: rtl/if_stage.sv
// Purpose : instruction-fetch stage; owns the PC, addresses a combinational IM
//           and loads the IF/ID register (ID_pc, ID_instruction, ID_valid).
// Latency : 1 edge from a fetch PC to its instruction appearing in IF/ID.
// Backpr. : stall freezes pc and IF/ID; redirect overrides stall.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   stall               hold pc and IF/ID this cycle
//   redirect            taken branch/jump resolved in ID; redirect_pc is its target
//   im_addr / im_rdata  IM word index (from pc only) and its combinational read data
//   pc                  current fetch PC
//   ID_pc, ID_instruction, ID_valid   IF/ID pipeline register
//   fetch_fault         sticky: out-of-range/misaligned fetch or misaligned redirect
//   fetch_count         number of valid instructions loaded into IF/ID (wraps)
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_AW      = 10,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      ID_pc,
  output logic [31:0]      ID_instruction,
  output logic             ID_valid,
  output logic             fetch_fault,
  output logic [31:0]      fetch_count
);

  // Offset of the fetch PC inside IM. Working on the offset rather than on
  // IM_BASE + size avoids overflow when IM sits at the top of the address map.
  logic [31:0] pc_offset;
  logic        fetch_ok;
  logic [31:0] fetch_word;

  assign pc_offset = pc - IM_BASE;
  assign im_addr   = pc_offset[IM_AW+1:2];

  assign fetch_ok = (pc >= IM_BASE) &&
                    ((pc_offset >> (IM_AW + 2)) == 32'd0) &&
                    (pc[1:0] == 2'b00);

  // A bad fetch still executes, but as a nop.
  assign fetch_word = fetch_ok ? im_rdata : 32'h0;

  logic [31:0] pc_nxt;
  logic [31:0] id_pc_nxt;
  logic [31:0] id_instruction_nxt;
  logic        id_valid_nxt;
  logic        fetch_fault_nxt;
  logic [31:0] fetch_count_nxt;
  logic        load;

  always_comb begin
    pc_nxt             = pc;
    id_pc_nxt          = ID_pc;
    id_instruction_nxt = ID_instruction;
    id_valid_nxt       = ID_valid;
    fetch_fault_nxt    = fetch_fault;
    fetch_count_nxt    = fetch_count;
    load               = 1'b0;

    if (redirect) begin
      pc_nxt = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        fetch_fault_nxt = 1'b1;
      end
      if (DELAY_SLOT != 1'b0) begin
        // The instruction behind the branch is the delay slot and executes.
        load = 1'b1;
      end else begin
        id_pc_nxt          = 32'h0;
        id_instruction_nxt = 32'h0;
        id_valid_nxt       = 1'b0;
      end
    end else if (!stall) begin
      pc_nxt = pc + 32'd4;
      load   = 1'b1;
    end

    if (load) begin
      id_pc_nxt          = pc;
      id_instruction_nxt = fetch_word;
      id_valid_nxt       = 1'b1;
      fetch_count_nxt    = fetch_count + 32'd1;
      if (!fetch_ok) begin
        fetch_fault_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc             <= RESET_PC;
      ID_pc          <= 32'h0;
      ID_instruction <= 32'h0;
      ID_valid       <= 1'b0;
      fetch_fault    <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      pc             <= pc_nxt;
      ID_pc          <= id_pc_nxt;
      ID_instruction <= id_instruction_nxt;
      ID_valid       <= id_valid_nxt;
      fetch_fault    <= fetch_fault_nxt;
      fetch_count    <= fetch_count_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam int          AW     = 10;
  localparam int          NWORDS = 1 << AW;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [AW-1:0] im_addr0, im_addr1;
  logic [31:0]   im_rdata0, im_rdata1;
  logic [31:0]   pc0, id_pc0, id_ins0, cnt0;
  logic [31:0]   pc1, id_pc1, id_ins1, cnt1;
  logic          v0, f0, v1, f1;

  logic [31:0] im [NWORDS];

  assign im_rdata0 = im[im_addr0];
  assign im_rdata1 = im[im_addr1];

  if_stage #(.RESET_PC(BASE), .IM_BASE(BASE), .IM_AW(AW), .DELAY_SLOT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_addr(im_addr0), .im_rdata(im_rdata0),
    .pc(pc0), .ID_pc(id_pc0), .ID_instruction(id_ins0), .ID_valid(v0),
    .fetch_fault(f0), .fetch_count(cnt0)
  );

  if_stage #(.RESET_PC(BASE), .IM_BASE(BASE), .IM_AW(AW), .DELAY_SLOT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_addr(im_addr1), .im_rdata(im_rdata1),
    .pc(pc1), .ID_pc(id_pc1), .ID_instruction(id_ins1), .ID_valid(v1),
    .fetch_fault(f1), .fetch_count(cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural view of the fetch stage, advanced one clock edge at a time.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_ins;
    logic        valid;
    logic        fault;
    logic [31:0] cnt;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.pc = BASE; s.id_pc = 0; s.id_ins = 0; s.valid = 0; s.fault = 0; s.cnt = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input bit st, input bit rd,
                                     input logic [31:0] rpc, input bit ds);
    mstate_t n = s;
    longint unsigned p = s.pc;
    bit ok = (p >= BASE) && (p < BASE + 4 * NWORDS) && (p % 4 == 0);
    logic [31:0] ins = ok ? im[(p - BASE) / 4] : 32'h0;
    bit take = 0;
    if (rd) begin
      n.pc = rpc - (rpc % 4);
      if (rpc % 4 != 0) n.fault = 1;
      if (ds) take = 1;
      else begin n.id_pc = 0; n.id_ins = 0; n.valid = 0; end
    end else if (!st) begin
      n.pc = s.pc + 4;
      take = 1;
    end
    if (take) begin
      n.id_pc = s.pc; n.id_ins = ins; n.valid = 1; n.cnt = s.cnt + 1;
      if (!ok) n.fault = 1;
    end
    return n;
  endfunction

  task automatic chk_model(input string tag, input mstate_t m, input logic [31:0] p,
                           input logic [31:0] ip, input logic [31:0] ii, input logic v,
                           input logic f, input logic [31:0] c);
    chk({tag, ".pc"}, p, m.pc);
    chk({tag, ".ID_pc"}, ip, m.id_pc);
    chk({tag, ".ID_instruction"}, ii, m.id_ins);
    chk({tag, ".ID_valid"}, {31'b0, v}, {31'b0, m.valid});
    chk({tag, ".fetch_fault"}, {31'b0, f}, {31'b0, m.fault});
    chk({tag, ".fetch_count"}, c, m.cnt);
  endtask

  task automatic chk_both(input string tag);
    chk_model({tag, ".ds0"}, m0, pc0, id_pc0, id_ins0, v0, f0, cnt0);
    chk_model({tag, ".ds1"}, m1, pc1, id_pc1, id_ins1, v1, f1, cnt1);
  endtask

  // Inputs are driven just after an edge, so they are stable for the next one.
  task automatic apply(input bit st, input bit rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clock);
    #1;
    m0 = m_step(m0, st, rd, rpc, 1'b0);
    m1 = m_step(m1, st, rd, rpc, 1'b1);
  endtask

  task automatic pulse_reset();
    stall = 0; redirect = 0; redirect_pc = 0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m0 = m_reset();
    m1 = m_reset();
  endtask

  typedef struct {
    bit          st;
    bit          rd;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_ins;
    bit          v;
    bit          f;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[15];

  initial begin
    // Expected DELAY_SLOT=0 behaviour after reset, one row per clock edge.
    vt[0]  = '{0, 0, 32'h0,    32'h3004, 32'h3000, 32'h11111111, 1, 0, 32'd1};
    vt[1]  = '{0, 0, 32'h0,    32'h3008, 32'h3004, 32'h22222222, 1, 0, 32'd2};
    vt[2]  = '{1, 0, 32'h0,    32'h3008, 32'h3004, 32'h22222222, 1, 0, 32'd2};
    vt[3]  = '{1, 0, 32'h0,    32'h3008, 32'h3004, 32'h22222222, 1, 0, 32'd2};
    vt[4]  = '{0, 0, 32'h0,    32'h300C, 32'h3008, 32'h33333333, 1, 0, 32'd3};
    vt[5]  = '{0, 1, 32'h3040, 32'h3040, 32'h0,    32'h0,        0, 0, 32'd3};
    vt[6]  = '{0, 0, 32'h0,    32'h3044, 32'h3040, 32'hC0000010, 1, 0, 32'd4};
    vt[7]  = '{1, 1, 32'h3020, 32'h3020, 32'h0,    32'h0,        0, 0, 32'd4};
    vt[8]  = '{0, 0, 32'h0,    32'h3024, 32'h3020, 32'hC0000008, 1, 0, 32'd5};
    vt[9]  = '{0, 1, 32'h3023, 32'h3020, 32'h0,    32'h0,        0, 1, 32'd5};
    vt[10] = '{0, 0, 32'h0,    32'h3024, 32'h3020, 32'hC0000008, 1, 1, 32'd6};
    vt[11] = '{0, 1, 32'h0,    32'h0,    32'h0,    32'h0,        0, 1, 32'd6};
    vt[12] = '{0, 0, 32'h0,    32'h4,    32'h0,    32'h0,        1, 1, 32'd7};
    vt[13] = '{0, 1, 32'h3000, 32'h3000, 32'h0,    32'h0,        0, 1, 32'd7};
    vt[14] = '{0, 0, 32'h0,    32'h3004, 32'h3000, 32'h11111111, 1, 1, 32'd8};

    im[0] = 32'h11111111; im[1] = 32'h22222222;
    im[2] = 32'h33333333; im[3] = 32'h44444444;
    for (int i = 4; i < NWORDS; i++) im[i] = 32'hC000_0000 | i;

    reset = 1'b0; stall = 0; redirect = 0; redirect_pc = 0;
    m0 = m_reset(); m1 = m_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_both("reset");
    reset = 1'b1;

    // Table: DELAY_SLOT=0 instance against constants, DELAY_SLOT=1 against the model.
    for (int i = 0; i < 15; i++) begin
      apply(vt[i].st, vt[i].rd, vt[i].rpc);
      chk($sformatf("vec%0d.pc", i), pc0, vt[i].pc);
      chk($sformatf("vec%0d.ID_pc", i), id_pc0, vt[i].id_pc);
      chk($sformatf("vec%0d.ID_instruction", i), id_ins0, vt[i].id_ins);
      chk($sformatf("vec%0d.ID_valid", i), {31'b0, v0}, {31'b0, vt[i].v});
      chk($sformatf("vec%0d.fetch_fault", i), {31'b0, f0}, {31'b0, vt[i].f});
      chk($sformatf("vec%0d.fetch_count", i), cnt0, vt[i].cnt);
      chk_model($sformatf("vec%0d.ds1", i), m1, pc1, id_pc1, id_ins1, v1, f1, cnt1);
    end

    // Delay slot: redirect while pc=300C.
    pulse_reset();
    apply(0, 0, 0); apply(0, 0, 0); apply(0, 0, 0);
    chk("ds.pre_pc", pc1, 32'h300C);
    apply(0, 1, 32'h3040);
    chk("ds1.slot_ID_pc", id_pc1, 32'h300C);
    chk("ds1.slot_instr", id_ins1, 32'h44444444);
    chk("ds1.slot_valid", {31'b0, v1}, 32'd1);
    chk("ds1.slot_count", cnt1, 32'd4);
    chk("ds0.bubble_valid", {31'b0, v0}, 32'd0);
    chk("ds0.bubble_instr", id_ins0, 32'h0);
    chk("ds0.bubble_count", cnt0, 32'd3);
    apply(0, 0, 0);
    chk("ds1.target_ID_pc", id_pc1, 32'h3040);
    chk("ds0.target_ID_pc", id_pc0, 32'h3040);
    chk("ds1.target_instr", id_ins1, 32'hC0000010);

    // Asynchronous reset between edges, with a redirect pending.
    apply(0, 0, 0);
    stall = 1; redirect = 1; redirect_pc = 32'h3040;
    #2;
    reset = 1'b0;
    #1;
    m0 = m_reset(); m1 = m_reset();
    chk_both("async_reset");
    #1;
    stall = 0; redirect = 0; redirect_pc = 0;
    reset = 1'b1;
    apply(0, 0, 0);
    chk("after_reset.ID_pc", id_pc0, 32'h3000);
    chk("after_reset.pc", pc0, 32'h3004);
    chk_both("after_reset");

    // Randomized traffic against the model, including IM edges and bad targets.
    for (int i = 0; i < 3000; i++) begin
      bit st = ($urandom_range(0, 99) < 25);
      bit rd = ($urandom_range(0, 99) < 15);
      logic [31:0] t;
      case ($urandom_range(0, 9))
        0:       t = $urandom;
        1:       t = BASE + 4 * NWORDS - 4;
        2:       t = BASE + 4 * NWORDS;
        3:       t = BASE - 4;
        4:       t = BASE + 4 * $urandom_range(0, NWORDS - 1) + $urandom_range(1, 3);
        default: t = BASE + 4 * $urandom_range(0, NWORDS - 1);
      endcase
      if ($urandom_range(0, 499) == 0) pulse_reset();
      apply(st, rd, t);
      chk_both($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
